// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset PC, NOP encoding and fetch FSM states.
// Also holds the fetch address check used when PC_CHECK_EN is defined.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // limit is one past the last legal byte address, kept 33 bits wide so it cannot wrap
    function automatic logic pc_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: PC, instruction word and fetch-fault flag, loaded when en=1.
// Same shape is reused for the D/E register.
module fd_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_instr,
    input  logic        next_exc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        exc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= PC_RESET;
            instr <= NOP;
            exc   <= 1'b0;
        end else if (en) begin
            pc    <= next_pc;
            instr <= next_instr;
            exc   <= next_exc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, req/rvalid fetch FSM and the F/D register.
// Define PC_CHECK_EN to suppress fetches from illegal PCs and flag them into D.
//
// state | meaning
// REQ   | issue request for pc; any response seen here is stale and dropped
// WAIT  | request outstanding; a response advances F/D or parks in the buffer
// HOLD  | word parked in the buffer while stalled; advance when stall drops
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    output logic [31:0] f_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        f_busy,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_exc
);

    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  buf_word;
    logic         buf_fault;
    logic [31:0]  word;
    logic         word_fault;
    logic         rsp_valid;
    logic [31:0]  adv_word;
    logic         adv_fault;
    logic         advance;
    logic         req_event;
    logic [31:0]  req_addr;
    logic         req_block;

    assign req_event = (state == REQ) || advance;
    assign req_addr  = (state == REQ) ? pc : npc;

`ifdef PC_CHECK_EN
    // A blocked fetch is answered internally on the next cycle with a faulting nop.
    logic fake_rsp;

    assign req_block  = pc_fault(req_addr, IM_BASE, IM_LIMIT);
    assign rsp_valid  = im_rvalid || fake_rsp;
    assign word       = fake_rsp ? NOP : im_rdata;
    assign word_fault = fake_rsp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fake_rsp <= 1'b0;
        end else if (req_event) begin
            fake_rsp <= req_block;
        end else if ((state == WAIT) && rsp_valid) begin
            fake_rsp <= 1'b0;
        end
    end
`else
    wire unused_cfg = ^IM_LIMIT;

    assign req_block  = 1'b0;
    assign rsp_valid  = im_rvalid;
    assign word       = im_rdata;
    assign word_fault = 1'b0;
`endif

    always_comb begin
        advance   = 1'b0;
        adv_word  = word;
        adv_fault = word_fault;
        f_busy    = 1'b1;
        case (state)
            REQ: begin
                f_busy = 1'b1;
            end
            WAIT: begin
                f_busy  = !rsp_valid;
                advance = rsp_valid && !stall;
            end
            HOLD: begin
                f_busy    = 1'b0;
                advance   = !stall;
                adv_word  = buf_word;
                adv_fault = buf_fault;
            end
            default: begin
                f_busy = 1'b1;
            end
        endcase
    end

    assign im_req  = req_event && !req_block;
    assign im_addr = req_addr;
    assign f_pc    = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= REQ;
            pc        <= PC_RESET;
            buf_word  <= NOP;
            buf_fault <= 1'b0;
        end else begin
            if (advance) begin
                pc <= npc;
            end
            case (state)
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rsp_valid && stall) begin
                        buf_word  <= word;
                        buf_fault <= word_fault;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    fd_reg #(
        .PC_RESET(PC_RESET)
    ) u_fd_reg (
        .clk        (clk),
        .reset      (reset),
        .en         (advance),
        .next_pc    (pc),
        .next_instr (adv_word),
        .next_exc   (adv_fault),
        .pc         (d_pc),
        .instr      (d_instr),
        .exc        (d_exc)
    );

endmodule
